// File: rtl/rv32v_vreg_file_lmul.sv
// rtl/rv32v_vreg_file_lmul.sv - vector register file with LMUL grouping, staged writes and whole-register move engine
module rv32v_vreg_file_lmul #(
    parameter int NUM_REGS = 32,
    parameter int VLEN     = 128,
    parameter int LANES    = 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [1:0]                sew,
    input  logic [$clog2(VLEN):0]     vl,
    input  logic                      wen,
    input  logic                      vm,
    input  logic [4:0]                vd,
    input  logic [$clog2(VLEN)-1:0]   vd_offset,
    input  logic [LANES*32-1:0]       w_data,
    input  logic [4:0]                vs1,
    input  logic [4:0]                vs2,
    input  logic [$clog2(VLEN)-1:0]   vs1_offset,
    input  logic [$clog2(VLEN)-1:0]   vs2_offset,
    output logic [LANES*32-1:0]       vs1_data,
    output logic [LANES*32-1:0]       vs2_data,
    input  logic                      mv_start,
    input  logic [4:0]                mv_src,
    input  logic [4:0]                mv_dst,
    input  logic [1:0]                mv_nregs,
    output logic                      mv_busy,
    output logic                      mv_done,
    output logic                      mv_err
);

    localparam int VLENB = VLEN / 8;
    localparam int RW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int BW    = (VLENB > 1) ? $clog2(VLENB) : 1;
    localparam int OW    = $clog2(VLEN);

    typedef enum logic [1:0] {IDLE, COPY, FIN} state_t;

    logic [VLEN-1:0]  regs_q [NUM_REGS];

    // One-entry write stage: each lane element lies wholly inside one register.
    logic             ws_valid_q, ws_valid_d;
    logic [LANES-1:0] ws_en_q, ws_en_d;
    logic [RW-1:0]    ws_reg_q  [LANES];
    logic [RW-1:0]    ws_reg_d  [LANES];
    logic [BW-1:0]    ws_byte_q [LANES];
    logic [BW-1:0]    ws_byte_d [LANES];
    logic [31:0]      ws_data_q [LANES];
    logic [31:0]      ws_data_d [LANES];
    logic [2:0]       ws_nb_q, ws_nb_d;

    state_t           state_q;
    logic [4:0]       src_q, dst_q;
    logic [2:0]       k_q, last_q;
    logic             mv_err_q;

    logic [VLEN-1:0]  v0_view;
    logic [VLEN-1:0]  copy_data;
    logic             wr_accept;
    logic             mv_ok;
    int               mv_n;

    function automatic int sew_bytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic [VLEN-1:0] fwd_reg(input int r);
        logic [VLEN-1:0] v;
        if (r < NUM_REGS) v = regs_q[RW'(r)];
        else              v = '0;
        if (ws_valid_q && r < NUM_REGS) begin
            for (int l = 0; l < LANES; l++) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws_en_q[l] && b < int'(ws_nb_q) && int'(ws_reg_q[l]) == r)
                        v[(int'(ws_byte_q[l]) + b)*8 +: 8] = ws_data_q[l][b*8 +: 8];
                end
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] read_lane(input logic [4:0] base,
                                              input logic [OW-1:0] off,
                                              input int lane);
        logic [VLEN-1:0] v;
        logic [31:0]     res;
        int              e, w, ba, r, bo;
        res = '0;
        w   = sew_bytes(sew);
        e   = int'(off) + lane;
        if (sew != 2'b11 && e < int'(vl)) begin
            ba = e * w;
            r  = int'(base) + ba / VLENB;
            bo = ba % VLENB;
            if (r < NUM_REGS) begin
                v = fwd_reg(r);
                for (int b = 0; b < 4; b++) begin
                    if (b < w) res[b*8 +: 8] = v[(bo + b)*8 +: 8];
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        int e, ba, r, nb;
        logic mask_ok;
        e         = 0;
        ba        = 0;
        r         = 0;
        mask_ok   = 1'b0;
        nb        = sew_bytes(sew);
        v0_view   = fwd_reg(0);
        wr_accept = wen && (state_q == IDLE) && (sew != 2'b11);
        ws_valid_d = wr_accept;
        ws_nb_d    = 3'(nb);
        for (int l = 0; l < LANES; l++) begin
            e  = int'(vd_offset) + l;
            ba = e * nb;
            r  = int'(vd) + ba / VLENB;
            mask_ok      = vm || (e < VLEN && v0_view[OW'(e)]);
            ws_en_d[l]   = wr_accept && (e < int'(vl)) && (r < NUM_REGS) && mask_ok;
            ws_reg_d[l]  = RW'(r);
            ws_byte_d[l] = BW'(ba % VLENB);
            ws_data_d[l] = w_data[l*32 +: 32];
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            vs1_data[l*32 +: 32] = read_lane(vs1, vs1_offset, l);
            vs2_data[l*32 +: 32] = read_lane(vs2, vs2_offset, l);
        end
    end

    always_comb begin
        mv_n  = 1 << mv_nregs;
        mv_ok = (int'(mv_src) % mv_n == 0) && (int'(mv_dst) % mv_n == 0) &&
                (int'(mv_src) + mv_n <= NUM_REGS) && (int'(mv_dst) + mv_n <= NUM_REGS);
        copy_data = fwd_reg(int'(src_q) + int'(k_q));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            ws_valid_q <= 1'b0;
            ws_en_q    <= '0;
            ws_nb_q    <= '0;
            for (int l = 0; l < LANES; l++) begin
                ws_reg_q[l]  <= '0;
                ws_byte_q[l] <= '0;
                ws_data_q[l] <= '0;
            end
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            k_q      <= '0;
            last_q   <= '0;
            mv_err_q <= 1'b0;
        end else begin
            ws_valid_q <= ws_valid_d;
            ws_en_q    <= ws_en_d;
            ws_nb_q    <= ws_nb_d;
            for (int l = 0; l < LANES; l++) begin
                ws_reg_q[l]  <= ws_reg_d[l];
                ws_byte_q[l] <= ws_byte_d[l];
                ws_data_q[l] <= ws_data_d[l];
            end
            mv_err_q <= 1'b0;

            if (ws_valid_q) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ws_en_q[l] && b < int'(ws_nb_q))
                            regs_q[ws_reg_q[l]][(int'(ws_byte_q[l]) + b)*8 +: 8] <= ws_data_q[l][b*8 +: 8];
                    end
                end
            end

            // The copy is issued after the commit so a whole-register move wins on the same register.
            case (state_q)
                IDLE: begin
                    if (mv_start) begin
                        if (mv_ok) begin
                            state_q <= COPY;
                            src_q   <= mv_src;
                            dst_q   <= mv_dst;
                            k_q     <= '0;
                            last_q  <= 3'(mv_n - 1);
                        end else begin
                            mv_err_q <= 1'b1;
                        end
                    end
                end
                COPY: begin
                    regs_q[RW'(int'(dst_q) + int'(k_q))] <= copy_data;
                    if (k_q == last_q) state_q <= FIN;
                    else               k_q     <= k_q + 3'd1;
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mv_busy = (state_q != IDLE);
    assign mv_done = (state_q == FIN);
    assign mv_err  = mv_err_q;

endmodule

// File: tb/tb_rv32v_vreg_file_lmul.sv
// tb/tb_rv32v_vreg_file_lmul.sv - directed self-checking bench for rv32v_vreg_file_lmul
module tb_rv32v_vreg_file_lmul;

    logic        CLK;
    logic        nRST;
    logic [1:0]  sew;
    logic [7:0]  vl;
    logic        wen;
    logic        vm;
    logic [4:0]  vd;
    logic [6:0]  vd_offset;
    logic [63:0] w_data;
    logic [4:0]  vs1, vs2;
    logic [6:0]  vs1_offset, vs2_offset;
    logic [63:0] vs1_data, vs2_data;
    logic        mv_start;
    logic [4:0]  mv_src, mv_dst;
    logic [1:0]  mv_nregs;
    logic        mv_busy, mv_done, mv_err;

    int n_checks;
    int n_fail;

    rv32v_vreg_file_lmul #(.NUM_REGS(32), .VLEN(128), .LANES(2)) dut (
        .CLK(CLK), .nRST(nRST), .sew(sew), .vl(vl), .wen(wen), .vm(vm),
        .vd(vd), .vd_offset(vd_offset), .w_data(w_data),
        .vs1(vs1), .vs2(vs2), .vs1_offset(vs1_offset), .vs2_offset(vs2_offset),
        .vs1_data(vs1_data), .vs2_data(vs2_data),
        .mv_start(mv_start), .mv_src(mv_src), .mv_dst(mv_dst), .mv_nregs(mv_nregs),
        .mv_busy(mv_busy), .mv_done(mv_done), .mv_err(mv_err)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK); #1;
    endtask

    task automatic do_write(input logic [1:0] s, input logic [7:0] l, input logic [4:0] d,
                            input logic [6:0] off, input logic m, input logic [63:0] data);
        sew = s; vl = l; vd = d; vd_offset = off; vm = m; w_data = data; wen = 1'b1;
        @(posedge CLK); #1;
        wen = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, input logic [7:0] l, input logic [4:0] r, input logic [6:0] off);
        sew = s; vl = l; vs1 = r; vs1_offset = off; vs2 = r; vs2_offset = off;
        #1;
    endtask

    task automatic run_move(input logic [4:0] src, input logic [4:0] dst, input logic [1:0] nr,
                            output int busy_n, output int done_n);
        busy_n = 0; done_n = 0;
        mv_src = src; mv_dst = dst; mv_nregs = nr; mv_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            mv_start = 1'b0;
            if (mv_busy) busy_n++;
            if (mv_done) done_n++;
            if (!mv_busy) break;
        end
    endtask

    task automatic test_reset;
        rd(2'b10, 8'd4, 5'd0, 7'd0);
        n_checks++; if (vs1_data !== 64'h0) begin n_fail++; $display("FAIL reset_vs1: got %h expected %h", vs1_data, 64'h0); end
        n_checks++; if (vs2_data !== 64'h0) begin n_fail++; $display("FAIL reset_vs2: got %h expected %h", vs2_data, 64'h0); end
        n_checks++; if ({mv_busy, mv_done, mv_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", {mv_busy, mv_done, mv_err}, 3'b000); end
    endtask

    task automatic test_basic_write;
        do_write(2'b10, 8'd4, 5'd3, 7'd2, 1'b1, {32'hAAAA0001, 32'hBBBB0002});
        tick();
        rd(2'b10, 8'd4, 5'd3, 7'd2);
        n_checks++; if (vs1_data !== {32'hAAAA0001, 32'hBBBB0002}) begin n_fail++; $display("FAIL basic_vs1: got %h expected %h", vs1_data, {32'hAAAA0001, 32'hBBBB0002}); end
        n_checks++; if (vs2_data !== {32'hAAAA0001, 32'hBBBB0002}) begin n_fail++; $display("FAIL basic_vs2: got %h expected %h", vs2_data, {32'hAAAA0001, 32'hBBBB0002}); end
        rd(2'b10, 8'd4, 5'd3, 7'd0);
        n_checks++; if (vs1_data !== 64'h0) begin n_fail++; $display("FAIL basic_untouched: got %h expected %h", vs1_data, 64'h0); end
        rd(2'b01, 8'd8, 5'd3, 7'd4);
        n_checks++; if (vs1_data !== 64'h0000BBBB_00000002) begin n_fail++; $display("FAIL basic_sew16: got %h expected %h", vs1_data, 64'h0000BBBB_00000002); end
        rd(2'b10, 8'd3, 5'd3, 7'd2);
        n_checks++; if (vs1_data !== 64'h00000000_BBBB0002) begin n_fail++; $display("FAIL basic_rd_vl: got %h expected %h", vs1_data, 64'h00000000_BBBB0002); end
        rd(2'b11, 8'd4, 5'd3, 7'd2);
        n_checks++; if (vs1_data !== 64'h0) begin n_fail++; $display("FAIL basic_sew11: got %h expected %h", vs1_data, 64'h0); end
    endtask

    task automatic test_vl_forward;
        do_write(2'b10, 8'd3, 5'd5, 7'd2, 1'b1, {32'hAAAA0001, 32'hBBBB0002});
        rd(2'b10, 8'd4, 5'd5, 7'd2);
        n_checks++; if (vs1_data !== 64'h00000000_BBBB0002) begin n_fail++; $display("FAIL fwd_read: got %h expected %h", vs1_data, 64'h00000000_BBBB0002); end
        tick();
        rd(2'b10, 8'd4, 5'd5, 7'd2);
        n_checks++; if (vs2_data !== 64'h00000000_BBBB0002) begin n_fail++; $display("FAIL vl_lane1_dropped: got %h expected %h", vs2_data, 64'h00000000_BBBB0002); end
    endtask

    task automatic test_group_span;
        do_write(2'b00, 8'd17, 5'd8, 7'd15, 1'b1, {32'hFFFFFF22, 32'hFFFFFF11});
        tick();
        rd(2'b00, 8'd17, 5'd8, 7'd15);
        n_checks++; if (vs1_data !== 64'h00000022_00000011) begin n_fail++; $display("FAIL span_bytes: got %h expected %h", vs1_data, 64'h00000022_00000011); end
        rd(2'b10, 8'd8, 5'd8, 7'd3);
        n_checks++; if (vs1_data !== 64'h00000022_11000000) begin n_fail++; $display("FAIL span_words: got %h expected %h", vs1_data, 64'h00000022_11000000); end
        rd(2'b00, 8'd1, 5'd9, 7'd0);
        n_checks++; if (vs2_data !== 64'h00000000_00000022) begin n_fail++; $display("FAIL span_v9: got %h expected %h", vs2_data, 64'h00000000_00000022); end
    endtask

    task automatic test_mask;
        do_write(2'b00, 8'd1, 5'd0, 7'd0, 1'b1, {32'h0, 32'h01});
        tick();
        do_write(2'b10, 8'd2, 5'd12, 7'd0, 1'b0, {32'h22222222, 32'h11111111});
        tick();
        rd(2'b10, 8'd2, 5'd12, 7'd0);
        n_checks++; if (vs1_data !== 64'h00000000_11111111) begin n_fail++; $display("FAIL mask_elem0_only: got %h expected %h", vs1_data, 64'h00000000_11111111); end
    endtask

    task automatic test_out_of_range;
        do_write(2'b10, 8'd8, 5'd31, 7'd3, 1'b1, {32'h77777777, 32'h66666666});
        tick();
        rd(2'b10, 8'd8, 5'd31, 7'd3);
        n_checks++; if (vs1_data !== 64'h00000000_66666666) begin n_fail++; $display("FAIL oob_read: got %h expected %h", vs1_data, 64'h00000000_66666666); end
        rd(2'b10, 8'd1, 5'd0, 7'd0);
        n_checks++; if (vs1_data !== 64'h00000000_00000001) begin n_fail++; $display("FAIL oob_no_wrap_v0: got %h expected %h", vs1_data, 64'h00000000_00000001); end
    endtask

    task automatic test_move;
        int busy_n, done_n;
        do_write(2'b10, 8'd16, 5'd4, 7'd0,  1'b1, {32'h40000001, 32'h40000000});
        do_write(2'b10, 8'd16, 5'd4, 7'd4,  1'b1, {32'h50000001, 32'h50000000});
        do_write(2'b10, 8'd16, 5'd4, 7'd8,  1'b1, {32'h60000001, 32'h60000000});
        do_write(2'b10, 8'd16, 5'd4, 7'd12, 1'b1, {32'h70000001, 32'h70000000});
        tick();
        run_move(5'd4, 5'd8, 2'b10, busy_n, done_n);
        n_checks++; if (busy_n !== 5) begin n_fail++; $display("FAIL move_busy_cycles: got %0d expected %0d", busy_n, 5); end
        n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL move_done_pulses: got %0d expected %0d", done_n, 1); end
        rd(2'b10, 8'd16, 5'd8, 7'd0);
        n_checks++; if (vs1_data !== {32'h40000001, 32'h40000000}) begin n_fail++; $display("FAIL move_v8: got %h expected %h", vs1_data, {32'h40000001, 32'h40000000}); end
        rd(2'b10, 8'd16, 5'd8, 7'd2);
        n_checks++; if (vs1_data !== 64'h0) begin n_fail++; $display("FAIL move_v8_hi: got %h expected %h", vs1_data, 64'h0); end
        rd(2'b10, 8'd16, 5'd8, 7'd4);
        n_checks++; if (vs1_data !== {32'h50000001, 32'h50000000}) begin n_fail++; $display("FAIL move_v9: got %h expected %h", vs1_data, {32'h50000001, 32'h50000000}); end
        rd(2'b10, 8'd16, 5'd8, 7'd8);
        n_checks++; if (vs1_data !== {32'h60000001, 32'h60000000}) begin n_fail++; $display("FAIL move_v10: got %h expected %h", vs1_data, {32'h60000001, 32'h60000000}); end
        rd(2'b10, 8'd16, 5'd8, 7'd12);
        n_checks++; if (vs1_data !== {32'h70000001, 32'h70000000}) begin n_fail++; $display("FAIL move_v11: got %h expected %h", vs1_data, {32'h70000001, 32'h70000000}); end
    endtask

    task automatic test_move_error;
        mv_src = 5'd5; mv_dst = 5'd8; mv_nregs = 2'b01; mv_start = 1'b1;
        tick();
        mv_start = 1'b0;
        n_checks++; if ({mv_err, mv_busy} !== 2'b10) begin n_fail++; $display("FAIL err_pulse: got %b expected %b", {mv_err, mv_busy}, 2'b10); end
        tick();
        n_checks++; if (mv_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected %b", mv_err, 1'b0); end
        rd(2'b10, 8'd16, 5'd8, 7'd0);
        n_checks++; if (vs1_data !== {32'h40000001, 32'h40000000}) begin n_fail++; $display("FAIL err_no_change: got %h expected %h", vs1_data, {32'h40000001, 32'h40000000}); end
    endtask

    task automatic test_back_to_back;
        int busy_n, done_n;
        busy_n = 0; done_n = 0;
        sew = 2'b10; vl = 8'd4; vd = 5'd12; vd_offset = 7'd1; vm = 1'b1;
        w_data = {32'h44444444, 32'h33333333}; wen = 1'b1;
        mv_src = 5'd12; mv_dst = 5'd14; mv_nregs = 2'b01; mv_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (mv_busy) busy_n++;
            if (mv_done) done_n++;
            if (i == 0) begin
                vd = 5'd13; vd_offset = 7'd0; w_data = {32'h99999999, 32'h88888888}; wen = 1'b1;
                mv_src = 5'd0; mv_dst = 5'd16; mv_nregs = 2'b00; mv_start = 1'b1;
            end else begin
                wen = 1'b0; mv_start = 1'b0;
            end
            if (!mv_busy) break;
        end
        wen = 1'b0; mv_start = 1'b0;
        n_checks++; if (busy_n !== 3) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", busy_n, 3); end
        n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d expected %0d", done_n, 1); end
        tick();
        rd(2'b10, 8'd4, 5'd14, 7'd0);
        n_checks++; if (vs1_data !== {32'h33333333, 32'h11111111}) begin n_fail++; $display("FAIL b2b_copy_fwd_lo: got %h expected %h", vs1_data, {32'h33333333, 32'h11111111}); end
        rd(2'b10, 8'd4, 5'd14, 7'd2);
        n_checks++; if (vs1_data !== 64'h00000000_44444444) begin n_fail++; $display("FAIL b2b_copy_fwd_hi: got %h expected %h", vs1_data, 64'h00000000_44444444); end
        rd(2'b10, 8'd4, 5'd13, 7'd0);
        n_checks++; if (vs1_data !== 64'h0) begin n_fail++; $display("FAIL b2b_wen_ignored: got %h expected %h", vs1_data, 64'h0); end
        rd(2'b00, 8'd1, 5'd16, 7'd0);
        n_checks++; if (vs1_data !== 64'h0) begin n_fail++; $display("FAIL b2b_start_ignored: got %h expected %h", vs1_data, 64'h0); end
        run_move(5'd14, 5'd14, 2'b00, busy_n, done_n);
        n_checks++; if ({busy_n, done_n} !== {32'd2, 32'd1}) begin n_fail++; $display("FAIL self_move_cycles: got busy %0d done %0d expected busy 2 done 1", busy_n, done_n); end
        rd(2'b10, 8'd4, 5'd14, 7'd0);
        n_checks++; if (vs1_data !== {32'h33333333, 32'h11111111}) begin n_fail++; $display("FAIL self_move_data: got %h expected %h", vs1_data, {32'h33333333, 32'h11111111}); end
    endtask

    task automatic test_reset_mid_move;
        mv_src = 5'd4; mv_dst = 5'd16; mv_nregs = 2'b10; mv_start = 1'b1;
        tick();
        mv_start = 1'b0;
        n_checks++; if (mv_busy !== 1'b1) begin n_fail++; $display("FAIL mid_move_started: got %b expected %b", mv_busy, 1'b1); end
        tick();
        nRST = 1'b0;
        tick();
        n_checks++; if ({mv_busy, mv_done, mv_err} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_flags: got %b expected %b", {mv_busy, mv_done, mv_err}, 3'b000); end
        rd(2'b10, 8'd16, 5'd16, 7'd0);
        n_checks++; if (vs1_data !== 64'h0) begin n_fail++; $display("FAIL mid_reset_dst: got %h expected %h", vs1_data, 64'h0); end
        rd(2'b10, 8'd16, 5'd4, 7'd0);
        n_checks++; if (vs1_data !== 64'h0) begin n_fail++; $display("FAIL mid_reset_src: got %h expected %h", vs1_data, 64'h0); end
        nRST = 1'b1;
        tick();
        tick();
        n_checks++; if (mv_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle: got %b expected %b", mv_busy, 1'b0); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        nRST = 1'b0; sew = 2'b00; vl = 8'd0; wen = 1'b0; vm = 1'b1; vd = 5'd0; vd_offset = 7'd0;
        w_data = 64'h0; vs1 = 5'd0; vs2 = 5'd0; vs1_offset = 7'd0; vs2_offset = 7'd0;
        mv_start = 1'b0; mv_src = 5'd0; mv_dst = 5'd0; mv_nregs = 2'b00;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        nRST = 1'b1;
        tick();
        test_basic_write();
        test_vl_forward();
        test_group_span();
        test_mask();
        test_out_of_range();
        test_move();
        test_move_error();
        test_back_to_back();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
